// File: rtl/dm_ctrl_pkg.sv
// Shared constants and FSM state encoding for the data-memory round-robin arbiter.
package dm_ctrl_pkg;
  localparam int DM_NCORES = 4;
  localparam int DM_ADDR_W = 16;
  localparam int DM_DATA_W = 16;
  localparam int IDX_W     = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/dm_rr_arbiter_rr_pick4.sv
// Rotate-priority picker: first set elig bit starting at rr_ptr, wrapping modulo 4.
module rr_pick4
  import dm_ctrl_pkg::*;
(
  input  logic [3:0]       elig,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);
  // Scan farthest offset first so the nearest eligible core overwrites it.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (elig[rr_ptr + IDX_W'(k)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = rr_ptr + IDX_W'(k);
      end
    end
  end
endmodule

// File: rtl/dm_rr_arbiter.sv
// Four-core round-robin arbiter serialising loads/stores onto a single-port data memory.
module dm_rr_arbiter
  import dm_ctrl_pkg::*;
#(
  parameter int NCORES  = DM_NCORES,
  parameter int ADDR_W  = DM_ADDR_W,
  parameter int DATA_W  = DM_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCORES-1:0]        req,
  input  logic [NCORES-1:0]        wen,
  input  logic [NCORES*ADDR_W-1:0] maddr,
  input  logic [NCORES*DATA_W-1:0] wdata,
  output logic [NCORES*DATA_W-1:0] dout,
  output logic [NCORES-1:0]        ack,
  output logic                     busy,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_re,
  output logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_rdata
);
  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t             state, state_n;
  logic [IDX_W-1:0]   rr_ptr, g, pick_idx;
  logic               pick_vld, g_wen, cap;
  logic [NCORES-1:0]  served, elig, resp_set;
  logic [2:0]         lat_cnt;

  assign elig     = req & ~served;
  assign cap      = (state == WAIT) && (lat_cnt == LAT);
  assign resp_set = (state == RESP) ? (NCORES'(1) << g) : '0;

  rr_pick4 u_pick (
    .elig      (elig),
    .rr_ptr    (rr_ptr),
    .gnt_valid (pick_vld),
    .gnt_idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_vld) state_n = ISSUE;
      ISSUE:   state_n = g_wen ? RESP : WAIT;
      WAIT:    if (cap) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request inputs are only looked at in IDLE; everything after works from the latched grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      served    <= '0;
      lat_cnt   <= '0;
      g         <= '0;
      g_wen     <= 1'b0;
      dout      <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      busy   <= (state_n != IDLE);
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      ack    <= '0;
      // A dropped request clears the no-regrant flag, even in the ack cycle.
      served <= (served | resp_set) & req;
      case (state)
        IDLE: if (pick_vld) begin
          g         <= pick_idx;
          g_wen     <= wen[pick_idx];
          mem_addr  <= maddr[pick_idx*ADDR_W +: ADDR_W];
          mem_wdata <= wdata[pick_idx*DATA_W +: DATA_W];
          mem_re    <= ~wen[pick_idx];
          mem_we    <= wen[pick_idx];
        end
        ISSUE: begin
          lat_cnt <= 3'd1;
          if (g_wen) ack[g] <= 1'b1;
        end
        WAIT: begin
          if (cap) begin
            dout[g*DATA_W +: DATA_W] <= mem_rdata;
            ack[g]                   <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESP: rr_ptr <= g + IDX_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_rr_arbiter.sv
// Scoreboard bench for dm_rr_arbiter with a one-cycle-latency memory model.
module tb_dm_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, wen, ack;
  logic [63:0] maddr, wdata, dout;
  logic        busy, mem_re, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {int core; logic [15:0] data;} exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  logic [15:0] mem [0:255];

  dm_rr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .wen(wen), .maddr(maddr), .wdata(wdata),
    .dout(dout), .ack(ack), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      mem[0] <= 16'd1; mem[1] <= 16'd5; mem[2] <= 16'd2; mem[3] <= 16'd6;
      mem[5] <= 16'd9; mem[16] <= 16'd0;
    end else begin
      if (mem_we) begin
        mem[mem_addr[7:0]] <= mem_wdata;
        we_cnt <= we_cnt + 1;
      end
      if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle(int n);
    req = 4'b0; wen = 4'b0;
    repeat (n) tick();
  endtask

  task automatic set_core(int c, logic [15:0] a, logic [15:0] d, logic w);
    maddr[c*16 +: 16] = a;
    wdata[c*16 +: 16] = d;
    wen[c] = w;
  endtask

  task automatic wait_ack(output logic [3:0] a, output int n, output bit ok);
    ok = 1'b0; a = 4'b0; n = 0;
    while (!ok && n < 40) begin
      tick(); n++;
      if (ack !== 4'b0) begin ok = 1'b1; a = ack; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; wen = 4'b0;
    for (int c = 0; c < 4; c++) set_core(c, 16'(c), 16'h0, 1'b0);
    repeat (2) tick();
    n_cmp++; if (dout !== 64'h0)  begin n_bad++; $display("FAIL reset_dout got %h want 0", dout); end
    n_cmp++; if (ack !== 4'b0)    begin n_bad++; $display("FAIL reset_ack got %b want 0", ack); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (mem_re !== 1'b0 || mem_we !== 1'b0)
      begin n_bad++; $display("FAIL reset_strobes got re=%b we=%b want 0", mem_re, mem_we); end
    n_cmp++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0)
      begin n_bad++; $display("FAIL reset_membus got a=%h d=%h want 0", mem_addr, mem_wdata); end
  endtask

  task automatic test_contention();
    logic [3:0] a; int n; bit ok; exp_t e;
    sb.push_back('{0, 16'd1}); sb.push_back('{1, 16'd5});
    sb.push_back('{2, 16'd2}); sb.push_back('{3, 16'd6});
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(a, n, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL cont_timeout core %0d no ack", e.core); end
      else begin
        if (a !== (4'b1 << e.core)) begin n_bad++; $display("FAIL cont_ack got %b want %b", a, 4'b1 << e.core); end
        n_cmp++;
        if (dout[e.core*16 +: 16] !== e.data)
          begin n_bad++; $display("FAIL cont_dout core %0d got %h want %h", e.core, dout[e.core*16 +: 16], e.data); end
        n_cmp++;
        if (n !== ((k == 0) ? 3 : 4)) begin n_bad++; $display("FAIL cont_spacing k=%0d got %0d want %0d", k, n, (k == 0) ? 3 : 4); end
      end
    end
    repeat (3) tick();
    n_cmp++; if (busy !== 1'b0 || ack !== 4'b0)
      begin n_bad++; $display("FAIL cont_regrant got busy=%b ack=%b want 0", busy, ack); end
  endtask

  task automatic test_fairness();
    logic [3:0] a; int n; bit ok; exp_t e; bit saw_busy;
    drive_idle(2);
    set_core(0, 16'd0, 16'h0, 1'b0); set_core(3, 16'd3, 16'h0, 1'b0);
    req = 4'b0001; sb.push_back('{0, 16'd1});
    wait_ack(a, n, ok); e = sb.pop_front();
    n_cmp++; if (!ok || a !== 4'b0001) begin n_bad++; $display("FAIL fair_first got %b want 0001", a); end
    req = 4'b1001; sb.push_back('{3, 16'd6});
    wait_ack(a, n, ok); e = sb.pop_front();
    n_cmp++; if (!ok || a !== (4'b1 << e.core)) begin n_bad++; $display("FAIL fair_core4 got %b want 1000", a); end
    n_cmp++; if (dout[e.core*16 +: 16] !== e.data)
      begin n_bad++; $display("FAIL fair_dout got %h want %h", dout[e.core*16 +: 16], e.data); end
    saw_busy = 1'b0;
    repeat (6) begin tick(); if (busy !== 1'b0) saw_busy = 1'b1; end
    n_cmp++; if (saw_busy) begin n_bad++; $display("FAIL fair_noregrant got busy want idle"); end
    req = 4'b1000; tick();
    req = 4'b1001; sb.push_back('{0, 16'd1});
    wait_ack(a, n, ok); e = sb.pop_front();
    n_cmp++; if (!ok || a !== 4'b0001 || n !== 3)
      begin n_bad++; $display("FAIL fair_reserve got ack=%b n=%0d want 0001 n=3", a, n); end
    drive_idle(2);
  endtask

  task automatic test_single_read();
    logic [3:0] a; int n; bit ok; exp_t e; logic [63:0] prev, mask;
    drive_idle(2);
    prev = dout; mask = ~(64'hFFFF << 32);
    set_core(2, 16'h0005, 16'h0, 1'b0);
    req = 4'b0100; sb.push_back('{2, 16'd9});
    tick();
    n_cmp++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0005)
      begin n_bad++; $display("FAIL rd_issue got re=%b we=%b a=%h want 1 0 0005", mem_re, mem_we, mem_addr); end
    req = 4'b0;
    wait_ack(a, n, ok); e = sb.pop_front();
    n_cmp++; if (!ok || a !== 4'b0100 || n !== 2)
      begin n_bad++; $display("FAIL rd_ack got ack=%b n=%0d want 0100 n=2", a, n); end
    n_cmp++; if (dout[e.core*16 +: 16] !== e.data)
      begin n_bad++; $display("FAIL rd_dout got %h want %h", dout[e.core*16 +: 16], e.data); end
    n_cmp++; if ((dout & mask) !== (prev & mask))
      begin n_bad++; $display("FAIL rd_others got %h want %h", dout & mask, prev & mask); end
  endtask

  task automatic test_write_readback();
    logic [3:0] a; int n; bit ok; exp_t e; logic [63:0] prev; int we0;
    drive_idle(2);
    prev = dout; we0 = we_cnt;
    set_core(1, 16'h0010, 16'hABCD, 1'b1);
    req = 4'b0010;
    tick();
    n_cmp++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 16'h0010 || mem_wdata !== 16'hABCD)
      begin n_bad++; $display("FAIL wr_issue got we=%b re=%b a=%h d=%h want 1 0 0010 abcd", mem_we, mem_re, mem_addr, mem_wdata); end
    req = 4'b0;
    wait_ack(a, n, ok);
    n_cmp++; if (!ok || a !== 4'b0010 || n !== 1)
      begin n_bad++; $display("FAIL wr_ack got ack=%b n=%0d want 0010 n=1", a, n); end
    n_cmp++; if (dout !== prev) begin n_bad++; $display("FAIL wr_dout got %h want %h", dout, prev); end
    tick();
    n_cmp++; if (we_cnt - we0 !== 1) begin n_bad++; $display("FAIL wr_count got %0d want 1", we_cnt - we0); end
    set_core(1, 16'h0010, 16'h0, 1'b0);
    req = 4'b0010; sb.push_back('{1, 16'hABCD});
    tick(); req = 4'b0;
    wait_ack(a, n, ok); e = sb.pop_front();
    n_cmp++; if (!ok || a !== 4'b0010 || dout[e.core*16 +: 16] !== e.data)
      begin n_bad++; $display("FAIL wr_readback got ack=%b d=%h want 0010 %h", a, dout[e.core*16 +: 16], e.data); end
  endtask

  task automatic test_midop_reset();
    logic [3:0] a; int n; bit ok; exp_t e; bit saw_ack;
    drive_idle(2);
    set_core(0, 16'h0003, 16'h0, 1'b0);
    req = 4'b0001;
    tick(); tick();
    rst = 1'b1; req = 4'b0;
    tick();
    rst = 1'b0;
    n_cmp++; if (ack !== 4'b0 || mem_re !== 1'b0 || busy !== 1'b0 || dout !== 64'h0)
      begin n_bad++; $display("FAIL mid_reset got ack=%b re=%b busy=%b dout=%h want 0", ack, mem_re, busy, dout); end
    saw_ack = 1'b0;
    repeat (4) begin tick(); if (ack !== 4'b0) saw_ack = 1'b1; end
    n_cmp++; if (saw_ack) begin n_bad++; $display("FAIL mid_noack got ack want none"); end
    for (int c = 1; c < 4; c++) set_core(c, 16'(c), 16'h0, 1'b0);
    req = 4'b1111; sb.push_back('{0, 16'd6});
    tick(); req = 4'b0;
    wait_ack(a, n, ok); e = sb.pop_front();
    n_cmp++; if (!ok || a !== 4'b0001 || n !== 2)
      begin n_bad++; $display("FAIL mid_ptr got ack=%b n=%0d want 0001 n=2", a, n); end
    n_cmp++; if (dout[e.core*16 +: 16] !== e.data)
      begin n_bad++; $display("FAIL mid_data got %h want %h", dout[e.core*16 +: 16], e.data); end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; wen = 4'b0; maddr = '0; wdata = '0;
    test_reset();
    test_contention();
    test_fairness();
    test_single_read();
    test_write_readback();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end
endmodule
